usr_shift_sequencer: RTL and testbench
======================================

// Module: usr_shift_sequencer
// PURPOSE
//  Control stage sitting directly upstream of the universal shift register.
//  Accepts parallel words on a valid/ready handshake and drives the register's sel/d_paraller/d_series
//  inputs: one LOAD cycle, then WIDTH shift cycles.
//  Taps the register's parallel output q to present a serial bit stream with valid and word-done strobes.
//  Turns the register into a back-to-back parallel-to-serial converter.
// PARAMETERS
//  WIDTH     4      word width; must equal the shift register width (>=2)
//  CNT_W     $clog2(WIDTH)  bit counter width (derived, do not override)
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      asynchronous, active-low reset
//  in_valid     in   1      upstream word valid
//  in_data      in   WIDTH  upstream word
//  in_dir       in   1      0 = shift right (LSB first), 1 = shift left (MSB first); sampled with word
//  in_ready     out  1      sequencer can accept a word this cycle
//  sel          out  2      to shift reg: 00 hold, 01 load, 10 shift right, 11 shift left
//  d_paraller   out  WIDTH  to shift reg parallel data
//  d_series     out  1      to shift reg serial fill bit
//  q            in   WIDTH  from shift reg parallel output
//  ser_out      out  1      serial bit
//  ser_valid    out  1      ser_out is a valid bit this cycle
//  word_done    out  1      one-cycle pulse on the last bit of a word
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, word_r=0, dir_r=0, cnt=0.
//    sel=00, d_paraller=0, d_series=0, ser_valid=0, word_done=0, ser_out=0, in_ready=0 while reset low.
//  - FSM states IDLE, LOAD, SHIFT, PAR (PAR exists only with macro); all outputs Moore-decoded from state/regs.
//  - IDLE: in_ready=1, sel=00. On in_valid&in_ready: capture in_data->word_r, in_dir->dir_r; next LOAD.
//  - LOAD (1 cycle): sel=01, d_paraller=word_r, in_ready=0; next SHIFT with cnt=WIDTH-1.
//  - SHIFT (WIDTH cycles): sel = dir_r ? 11 : 10; ser_valid=1.
//    ser_out = dir_r ? q[WIDTH-1] : q[0] (bit before this cycle's shift); cnt decrements each cycle.
//  - Last SHIFT cycle (cnt==0): word_done=1 (no macro) and in_ready=1.
//    Accepted word -> LOAD next cycle (back-to-back, 1+WIDTH cycles/word); else -> IDLE.
//  - d_series = 0 always (zero fill); d_paraller = word_r in every state (only sampled on LOAD).
//  - in_data/in_dir changes while in_ready=0 are ignored; word_r is stable from capture to next capture.
//  - Counter never wraps: reload only on LOAD->SHIFT transition.
//  - Reset mid-word: immediate IDLE, partial word discarded; no word_done issued.
//  - Latency: accept edge -> first ser_valid is 2 cycles.
// CONFIGURATION
//  USR_SEQ_PARITY_EN defined:
//   - After the last SHIFT cycle, one PAR cycle: sel=00, ser_valid=1, ser_out = ^word_r (even parity).
//   - word_done and in_ready move from the last SHIFT cycle to PAR; 2+WIDTH cycles/word.
//  Undefined: no PAR state; timing as above.
// STRUCTURE
//  - Shared package/header usr_pkg: SEL_HOLD=2'b00, SEL_LOAD=2'b01, SEL_SHR=2'b10, SEL_SHL=2'b11.
//  - FSM state encodings also live in usr_pkg (so the register, this sequencer and benches agree).
//  - Single flat module; no sub-module. Bench instantiates usr_shift_sequencer + unishr with q fed back.
// TESTING
//  1. Reset held 3 cycles -> sel=00, in_ready=0, ser_valid=0; release -> in_ready=1 next cycle.
//  2. in_data=4'b1011, in_dir=0 -> sel 01 then 10x4; ser_out=1,1,0,1; word_done on 4th bit.
//  3. in_data=4'b1011, in_dir=1 -> sel 01 then 11x4; ser_out=1,0,1,1; q ends 0000.
//  4. in_valid held high, data 0..9 alternating dir -> 5 cycles/word, no gap.
//     Bit stream matches model; in_ready high only on last-bit cycles.
//  5. reset pulsed low on 2nd SHIFT cycle of 4'b0110 -> sel=00 asynchronously, no word_done.
//     Next word 4'b1001 serialises correctly.
//  6. With USR_SEQ_PARITY_EN: 4'b1011 dir=0 -> ser_out=1,1,0,1 then parity 1.
//     4'b0011 -> parity 0; 6 cycles/word back-to-back.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared select codes and sequencer state encodings for the universal shift register slice.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package usr_pkg;

    // Shift register operation select
    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_SHR  = 2'b10;
    localparam logic [1:0] SEL_SHL  = 2'b11;

    // Sequencer states; ST_PAR is only entered when parity generation is built in
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_PAR   = 2'd3
    } usr_seq_state_t;

    // Shift direction bit to register select code (1 = left/MSB first)
    function automatic logic [1:0] shift_sel(input logic dir);
        return dir ? SEL_SHL : SEL_SHR;
    endfunction

endpackage

// File: rtl/unishr.sv
// Universal shift register: hold, parallel load, shift right or left with serial fill.
// Latency: q updates one cycle after sel/d_paraller/d_series are presented.
// Backpressure: none; acts on sel every cycle.
//
// Ports: clk, reset (async active-low), sel[1:0], d_paraller[WIDTH-1:0], d_series, q[WIDTH-1:0]
module unishr
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] d_paraller,
    input  logic             d_series,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else begin
            case (sel)
                SEL_LOAD: q <= d_paraller;
                SEL_SHR:  q <= {d_series, q[WIDTH-1:1]};
                SEL_SHL:  q <= {q[WIDTH-2:0], d_series};
                default:  q <= q;
            endcase
        end
    end

endmodule

// File: rtl/usr_shift_sequencer.sv
// Drives unishr as a back-to-back parallel-to-serial converter (LOAD, then WIDTH shifts per word).
// Latency: first ser_valid two cycles after the accept cycle; 1+WIDTH cycles/word (2+WIDTH with parity).
// Backpressure: in_ready only in IDLE and on the final cycle of a word; words offered otherwise wait.
//
// Ports: clk, reset (async active-low); in_valid/in_data/in_dir/in_ready upstream word handshake;
//        sel/d_paraller/d_series to the shift register, q from it; ser_out/ser_valid/word_done serial side.
// Build option: USR_SEQ_PARITY_EN appends one even-parity bit per word (PAR state).
module usr_shift_sequencer
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    output logic             in_ready,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] d_paraller,
    output logic             d_series,
    input  logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    usr_seq_state_t   state;
    logic [WIDTH-1:0] word_r;
    logic             dir_r;
    logic [CNT_W-1:0] cnt;
    logic             run_r;   // keeps in_ready low until the first edge after reset release
    logic             accept;
    logic             unused_q;

    // Only the end bit selected by dir_r is tapped from q
    assign unused_q = ^q;

    assign accept     = in_valid & in_ready;
    assign d_paraller = word_r;
    assign d_series   = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            word_r <= '0;
            dir_r  <= 1'b0;
            cnt    <= '0;
            run_r  <= 1'b0;
        end else begin
            run_r <= 1'b1;
            if (accept) begin
                word_r <= in_data;
                dir_r  <= in_dir;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    state <= ST_SHIFT;
                    cnt   <= CNT_W'(WIDTH - 1);
                end
                ST_SHIFT: begin
                    // cnt parks at zero on the last bit; it is only reloaded from LOAD
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
`ifdef USR_SEQ_PARITY_EN
                        state <= ST_PAR;
`else
                        state <= accept ? ST_LOAD : ST_IDLE;
`endif
                    end
                end
                ST_PAR: begin
                    state <= accept ? ST_LOAD : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Moore decode; ser_out taps q before this cycle's shift takes effect
    always_comb begin
        in_ready  = 1'b0;
        sel       = SEL_HOLD;
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        word_done = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = run_r;
            end
            ST_LOAD: begin
                sel = SEL_LOAD;
            end
            ST_SHIFT: begin
                sel       = shift_sel(dir_r);
                ser_valid = 1'b1;
                ser_out   = dir_r ? q[WIDTH-1] : q[0];
`ifdef USR_SEQ_PARITY_EN
                word_done = 1'b0;
`else
                if (cnt == '0) begin
                    word_done = 1'b1;
                    in_ready  = 1'b1;
                end
`endif
            end
            ST_PAR: begin
`ifdef USR_SEQ_PARITY_EN
                ser_valid = 1'b1;
                ser_out   = ^word_r;
                word_done = 1'b1;
                in_ready  = 1'b1;
`else
                ser_valid = 1'b0;
`endif
            end
            default: begin
                sel = SEL_HOLD;
            end
        endcase
    end

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Directed bench: usr_shift_sequencer driving unishr with q fed back.
// Latency: n/a.
// Backpressure: n/a.
module tb_usr_shift_sequencer;
    import usr_pkg::*;

    localparam int W = 4;
`ifdef USR_SEQ_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int PER = PAR_EN ? (W + 2) : (W + 1);

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_dir;
    logic         in_ready;
    logic [1:0]   sel;
    logic [W-1:0] d_paraller;
    logic         d_series;
    logic [W-1:0] q;
    logic         ser_out;
    logic         ser_valid;
    logic         word_done;

    int n_checks = 0;
    int n_fail   = 0;

    usr_shift_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_dir     (in_dir),
        .in_ready   (in_ready),
        .sel        (sel),
        .d_paraller (d_paraller),
        .d_series   (d_series),
        .q          (q),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .word_done  (word_done)
    );

    unishr #(.WIDTH(W)) u_shr (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .d_paraller (d_paraller),
        .d_series   (d_series),
        .q          (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tasks start and end just after a falling edge; inputs change there and
    // are sampled by the DUT on the following rising edge.

    task automatic test_reset;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_dir   = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (sel !== SEL_HOLD || in_ready !== 1'b0 || ser_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: sel=%b in_ready=%b ser_valid=%b, want 00/0/0", sel, in_ready, ser_valid);
        end
        n_checks++;
        if (word_done !== 1'b0 || ser_out !== 1'b0 || d_series !== 1'b0 || d_paraller !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_data: word_done=%b ser_out=%b d_series=%b d_paraller=%b, want all zero",
                     word_done, ser_out, d_series, d_paraller);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_ready: in_ready=%b, want 0 before first edge", in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || sel !== SEL_HOLD) begin
            n_fail++;
            $display("FAIL post_reset_idle: in_ready=%b sel=%b, want 1/00", in_ready, sel);
        end
    endtask

    task automatic test_single_word(input logic [W-1:0] data, input logic dir, input string name);
        logic       exp_b;
        logic [1:0] exp_sel;
        exp_sel = dir ? SEL_SHL : SEL_SHR;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_ready: in_ready=%b, want 1", name, in_ready);
        end
        in_valid = 1'b1;
        in_data  = data;
        in_dir   = dir;
        @(negedge clk);
        // Garbage while not ready must be ignored
        in_valid = 1'b0;
        in_data  = ~data;
        in_dir   = ~dir;
        n_checks++;
        if (sel !== SEL_LOAD || in_ready !== 1'b0 || ser_valid !== 1'b0 || d_paraller !== data) begin
            n_fail++;
            $display("FAIL %s load: sel=%b in_ready=%b ser_valid=%b d_paraller=%b, want 01/0/0/%b",
                     name, sel, in_ready, ser_valid, d_paraller, data);
        end
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            exp_b = dir ? data[W-1-i] : data[i];
            n_checks++;
            if (sel !== exp_sel || ser_valid !== 1'b1 || ser_out !== exp_b) begin
                n_fail++;
                $display("FAIL %s bit%0d: sel=%b ser_valid=%b ser_out=%b, want %b/1/%b",
                         name, i, sel, ser_valid, ser_out, exp_sel, exp_b);
            end
            n_checks++;
            if (word_done !== ((i == W-1) && !PAR_EN) || in_ready !== ((i == W-1) && !PAR_EN)) begin
                n_fail++;
                $display("FAIL %s done_ready%0d: word_done=%b in_ready=%b, want %b",
                         name, i, word_done, in_ready, (i == W-1) && !PAR_EN);
            end
        end
`ifdef USR_SEQ_PARITY_EN
        @(negedge clk);
        n_checks++;
        if (sel !== SEL_HOLD || ser_valid !== 1'b1 || ser_out !== ^data || word_done !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s parity: sel=%b ser_valid=%b ser_out=%b word_done=%b in_ready=%b, want 00/1/%b/1/1",
                     name, sel, ser_valid, ser_out, word_done, in_ready, ^data);
        end
`endif
        @(negedge clk);
        n_checks++;
        if (sel !== SEL_HOLD || ser_valid !== 1'b0 || word_done !== 1'b0 || in_ready !== 1'b1 || q !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s back_to_idle: sel=%b ser_valid=%b word_done=%b in_ready=%b q=%b, want 00/0/0/1/0000",
                     name, sel, ser_valid, word_done, in_ready, q);
        end
    endtask

    task automatic test_back_to_back;
        int         k;
        int         done_cnt;
        int         nb;
        int         acc [10];
        logic       acc_now;
        logic [W-1:0] got;
        logic [W-1:0] exp_v;
        logic [W-1:0] w;
        logic       wdir;
        k        = 0;
        done_cnt = 0;
        nb       = 0;
        got      = '0;
        in_valid = 1'b1;
        in_data  = '0;
        in_dir   = 1'b0;
        for (int cyc = 0; cyc < 300 && done_cnt < 10; cyc++) begin
            if (k > 0) begin
                n_checks++;
                if (in_ready !== word_done) begin
                    n_fail++;
                    $display("FAIL b2b_ready cyc%0d: in_ready=%b, want %b (word_done)", cyc, in_ready, word_done);
                end
            end
            if (ser_valid === 1'b1 && sel !== SEL_HOLD && nb < W) begin
                got[nb] = ser_out;
                nb++;
            end
            if (word_done === 1'b1) begin
                w    = done_cnt[W-1:0];
                wdir = done_cnt[0];
                for (int i = 0; i < W; i++) exp_v[i] = wdir ? w[W-1-i] : w[i];
                n_checks++;
                if (got !== exp_v || nb != W) begin
                    n_fail++;
                    $display("FAIL b2b_word%0d: bits=%b count=%0d, want %b count=%0d", done_cnt, got, nb, exp_v, W);
                end
`ifdef USR_SEQ_PARITY_EN
                n_checks++;
                if (ser_out !== ^w) begin
                    n_fail++;
                    $display("FAIL b2b_parity%0d: ser_out=%b, want %b", done_cnt, ser_out, ^w);
                end
`endif
                done_cnt++;
                nb  = 0;
                got = '0;
            end
            acc_now = in_ready & in_valid;
            if (acc_now) begin
                acc[k] = cyc;
                k++;
            end
            @(posedge clk);
            #1;
            if (acc_now) begin
                if (k < 10) begin
                    in_data = k[W-1:0];
                    in_dir  = k[0];
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if (done_cnt != 10) begin
            n_fail++;
            $display("FAIL b2b_timeout: words done=%0d, want 10", done_cnt);
        end
        for (int j = 1; j < 10 && j < k; j++) begin
            n_checks++;
            if (acc[j] - acc[j-1] != PER) begin
                n_fail++;
                $display("FAIL b2b_spacing%0d: %0d cycles, want %0d", j, acc[j] - acc[j-1], PER);
            end
        end
    endtask

    task automatic test_reset_mid_word;
        in_valid = 1'b1;
        in_data  = 4'b0110;
        in_dir   = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ser_valid !== 1'b1 || ser_out !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_bit0: ser_valid=%b ser_out=%b, want 1/0", ser_valid, ser_out);
        end
        @(posedge clk);
        #2;
        n_checks++;
        if (ser_valid !== 1'b1 || ser_out !== 1'b1 || sel !== SEL_SHR) begin
            n_fail++;
            $display("FAIL midrst_bit1: ser_valid=%b ser_out=%b sel=%b, want 1/1/10", ser_valid, ser_out, sel);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (sel !== SEL_HOLD || ser_valid !== 1'b0 || word_done !== 1'b0 || in_ready !== 1'b0 || q !== 4'b0000) begin
            n_fail++;
            $display("FAIL midrst_async: sel=%b ser_valid=%b word_done=%b in_ready=%b q=%b, want 00/0/0/0/0000",
                     sel, ser_valid, word_done, in_ready, q);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || word_done !== 1'b0 || ser_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_recover: in_ready=%b word_done=%b ser_valid=%b, want 1/0/0",
                     in_ready, word_done, ser_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_word(4'b1011, 1'b0, "shr_1011");
        test_single_word(4'b1011, 1'b1, "shl_1011");
`ifdef USR_SEQ_PARITY_EN
        test_single_word(4'b0011, 1'b0, "par_0011");
`endif
        test_back_to_back();
        @(negedge clk);
        test_reset_mid_word();
        test_single_word(4'b1001, 1'b0, "after_rst_1001");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
